// File: rtl/sobel_edge_magnitude_pipeline.sv
// Sobel edge magnitude pipeline.
// Accepts 3x3 grayscale neighbourhoods from the buffered colorspace converter.
// Upstream holds ready for several cycles on the same pixel, so repeated
// presentations of one position are dropped here. Each result carries
// |Gx|+|Gy| saturated to the pixel depth and an edge bit from a threshold
// compare. Edge pixels are counted per frame.
// Latency is three cycles from accept to O_VALID.
module sobel_edge_magnitude_pipeline #(
    parameter int P_SUBPIXEL_DEPTH    = 8,
    parameter int P_FRAME_COLUMNS     = 640,
    parameter int P_FRAME_ROWS        = 480,
    parameter int P_LAST_COLUMN       = P_FRAME_COLUMNS - 4,
    parameter int P_LAST_ROW          = P_FRAME_ROWS - 4,
    parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
    parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
    parameter int P_PIXEL_MATRIX_BITS = 8 * P_SUBPIXEL_DEPTH,
    parameter int P_COUNT_BITS        = $clog2(P_FRAME_COLUMNS * P_FRAME_ROWS + 1)
) (
    input  logic                           I_CLK,
    input  logic                           I_RESET,
    input  logic [P_FRAME_COLUMN_BITS-1:0] I_PIXEL_COLUMN,
    input  logic [P_FRAME_ROW_BITS-1:0]    I_PIXEL_ROW,
    input  logic [P_PIXEL_MATRIX_BITS-1:0] I_PIXEL_MATRIX,
    input  logic                           I_PIXEL_MATRIX_READY,
    input  logic [P_SUBPIXEL_DEPTH-1:0]    I_THRESHOLD,
    output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
    output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
    output logic [P_SUBPIXEL_DEPTH-1:0]    O_EDGE_MAGNITUDE,
    output logic                           O_EDGE,
    output logic                           O_VALID,
    output logic [P_COUNT_BITS-1:0]        O_EDGE_COUNT,
    output logic                           O_FRAME_DONE
);

    localparam int LP_W  = P_SUBPIXEL_DEPTH;
    localparam int LP_SW = P_SUBPIXEL_DEPTH + 2;   // weighted sum / abs diff width
    localparam int LP_MW = P_SUBPIXEL_DEPTH + 3;   // |Gx|+|Gy| width
    localparam int LP_CB = P_FRAME_COLUMN_BITS;
    localparam int LP_RB = P_FRAME_ROW_BITS;
    localparam int LP_NB = P_COUNT_BITS;

    localparam logic [LP_CB-1:0] LP_LAST_COL = LP_CB'(P_LAST_COLUMN);
    localparam logic [LP_RB-1:0] LP_LAST_ROW = LP_RB'(P_LAST_ROW);

    // ------------------------------------------------------------------
    // Neighbourhood unpack, tl in the MSBs
    // ------------------------------------------------------------------
    logic [LP_W-1:0] w_tl, w_t, w_tr, w_ml, w_mr, w_bl, w_b, w_br;

    assign w_tl = I_PIXEL_MATRIX[8*LP_W-1 -: LP_W];
    assign w_t  = I_PIXEL_MATRIX[7*LP_W-1 -: LP_W];
    assign w_tr = I_PIXEL_MATRIX[6*LP_W-1 -: LP_W];
    assign w_ml = I_PIXEL_MATRIX[5*LP_W-1 -: LP_W];
    assign w_mr = I_PIXEL_MATRIX[4*LP_W-1 -: LP_W];
    assign w_bl = I_PIXEL_MATRIX[3*LP_W-1 -: LP_W];
    assign w_b  = I_PIXEL_MATRIX[2*LP_W-1 -: LP_W];
    assign w_br = I_PIXEL_MATRIX[LP_W-1 -: LP_W];

    // ------------------------------------------------------------------
    // Duplicate suppression
    // ------------------------------------------------------------------
    logic             r_seen;
    logic [LP_CB-1:0] r_last_col;
    logic [LP_RB-1:0] r_last_row;
    logic             w_accept;

    assign w_accept = I_PIXEL_MATRIX_READY &&
                      (!r_seen || (I_PIXEL_COLUMN != r_last_col) || (I_PIXEL_ROW != r_last_row));

    // Remember the last accepted position; ready dropping does not forget it
    always_ff @(posedge I_CLK) begin
        // NOTE: every clocked assignment is non-blocking so all stages update from pre-edge values.
        if (I_RESET) begin
            r_seen     <= 1'b0;
            r_last_col <= '0;
            r_last_row <= '0;
        end else if (w_accept) begin
            r_seen     <= 1'b1;
            r_last_col <= I_PIXEL_COLUMN;
            r_last_row <= I_PIXEL_ROW;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: weighted positive/negative column and row sums
    // ------------------------------------------------------------------
    logic [LP_SW-1:0] w_gxp, w_gxn, w_gyp, w_gyn;

    assign w_gxp = {2'b00, w_tr} + {1'b0, w_mr, 1'b0} + {2'b00, w_br};
    assign w_gxn = {2'b00, w_tl} + {1'b0, w_ml, 1'b0} + {2'b00, w_bl};
    assign w_gyp = {2'b00, w_bl} + {1'b0, w_b,  1'b0} + {2'b00, w_br};
    assign w_gyn = {2'b00, w_tl} + {1'b0, w_t,  1'b0} + {2'b00, w_tr};

    logic             r_s1_valid;
    logic [LP_CB-1:0] r_s1_col;
    logic [LP_RB-1:0] r_s1_row;
    logic [LP_W-1:0]  r_s1_thr;
    logic [LP_SW-1:0] r_s1_gxp, r_s1_gxn, r_s1_gyp, r_s1_gyn;

    // Register the sums together with position and threshold of the accepted matrix
    always_ff @(posedge I_CLK) begin
        // NOTE: datapath registers are reset too so a reset leaves every output at zero.
        if (I_RESET) begin
            r_s1_valid <= 1'b0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_s1_thr   <= '0;
            r_s1_gxp   <= '0;
            r_s1_gxn   <= '0;
            r_s1_gyp   <= '0;
            r_s1_gyn   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_col <= I_PIXEL_COLUMN;
                r_s1_row <= I_PIXEL_ROW;
                r_s1_thr <= I_THRESHOLD;
                r_s1_gxp <= w_gxp;
                r_s1_gxn <= w_gxn;
                r_s1_gyp <= w_gyp;
                r_s1_gyn <= w_gyn;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: absolute gradients as larger minus smaller
    // ------------------------------------------------------------------
    logic [LP_SW-1:0] w_abs_gx, w_abs_gy;

    assign w_abs_gx = (r_s1_gxp >= r_s1_gxn) ? (r_s1_gxp - r_s1_gxn) : (r_s1_gxn - r_s1_gxp);
    assign w_abs_gy = (r_s1_gyp >= r_s1_gyn) ? (r_s1_gyp - r_s1_gyn) : (r_s1_gyn - r_s1_gyp);

    logic             r_s2_valid;
    logic [LP_CB-1:0] r_s2_col;
    logic [LP_RB-1:0] r_s2_row;
    logic [LP_W-1:0]  r_s2_thr;
    logic [LP_SW-1:0] r_s2_abs_gx, r_s2_abs_gy;

    // Register the absolute gradients and the travelling side information
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_s2_valid  <= 1'b0;
            r_s2_col    <= '0;
            r_s2_row    <= '0;
            r_s2_thr    <= '0;
            r_s2_abs_gx <= '0;
            r_s2_abs_gy <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_col    <= r_s1_col;
                r_s2_row    <= r_s1_row;
                r_s2_thr    <= r_s1_thr;
                r_s2_abs_gx <= w_abs_gx;
                r_s2_abs_gy <= w_abs_gy;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude, saturation, threshold and frame counting
    // ------------------------------------------------------------------
    logic [LP_MW-1:0] w_mag;
    logic [LP_W-1:0]  w_mag_sat;
    logic             w_edge;
    logic             w_last_pos;
    logic [LP_NB-1:0] w_running_next;

    assign w_mag      = {1'b0, r_s2_abs_gx} + {1'b0, r_s2_abs_gy};
    assign w_mag_sat  = (|w_mag[LP_MW-1:LP_W]) ? {LP_W{1'b1}} : w_mag[LP_W-1:0];
    assign w_edge     = (w_mag_sat >= r_s2_thr);
    assign w_last_pos = (r_s2_col == LP_LAST_COL) && (r_s2_row == LP_LAST_ROW);

    logic [LP_NB-1:0] r_running;

    // Running count including the current result, held at full scale instead of wrapping
    assign w_running_next = (w_edge && (r_running != {LP_NB{1'b1}})) ? (r_running + LP_NB'(1)) : r_running;

    logic             r_valid;
    logic [LP_CB-1:0] r_col;
    logic [LP_RB-1:0] r_row;
    logic [LP_W-1:0]  r_mag;
    logic             r_edge;

    // Present one result per accepted matrix; result fields hold between pulses
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_valid <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_mag   <= '0;
            r_edge  <= 1'b0;
        end else begin
            r_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_col  <= r_s2_col;
                r_row  <= r_s2_row;
                r_mag  <= w_mag_sat;
                r_edge <= w_edge;
            end
        end
    end

    logic [LP_NB-1:0] r_edge_count;
    logic             r_frame_done;

    // Count edges and publish the total when the last matrix position of a frame completes
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_running    <= '0;
            r_edge_count <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_s2_valid) begin
                if (w_last_pos) begin
                    r_edge_count <= w_running_next;
                    r_frame_done <= 1'b1;
                    r_running    <= '0;
                end else begin
                    r_running <= w_running_next;
                end
            end
        end
    end

    assign O_PIXEL_COLUMN   = r_col;
    assign O_PIXEL_ROW      = r_row;
    assign O_EDGE_MAGNITUDE = r_mag;
    assign O_EDGE           = r_edge;
    assign O_VALID          = r_valid;
    assign O_EDGE_COUNT     = r_edge_count;
    assign O_FRAME_DONE     = r_frame_done;

endmodule

// File: tb/tb_sobel_edge_magnitude_pipeline.sv
// Scoreboard bench for sobel_edge_magnitude_pipeline: the driver predicts each
// accepted matrix's result from the Sobel rules and queues it; the monitor pops
// and compares whenever O_VALID is seen. The last position is shrunk to (2,1)
// so frames complete quickly.
module tb_sobel_edge_magnitude_pipeline;

    localparam int CB   = 10;
    localparam int RB   = 9;
    localparam int NB   = 19;
    localparam int LAST_C = 2;
    localparam int LAST_R = 1;
    localparam int CNT_MAX = (1 << NB) - 1;

    logic          clk = 1'b0;
    logic          I_RESET = 1'b1;
    logic [CB-1:0] I_PIXEL_COLUMN = '0;
    logic [RB-1:0] I_PIXEL_ROW = '0;
    logic [63:0]   I_PIXEL_MATRIX = '0;
    logic          I_PIXEL_MATRIX_READY = 1'b0;
    logic [7:0]    I_THRESHOLD = '0;
    logic [CB-1:0] O_PIXEL_COLUMN;
    logic [RB-1:0] O_PIXEL_ROW;
    logic [7:0]    O_EDGE_MAGNITUDE;
    logic          O_EDGE;
    logic          O_VALID;
    logic [NB-1:0] O_EDGE_COUNT;
    logic          O_FRAME_DONE;

    sobel_edge_magnitude_pipeline #(
        .P_LAST_COLUMN(LAST_C),
        .P_LAST_ROW   (LAST_R)
    ) dut (
        .I_CLK               (clk),
        .I_RESET             (I_RESET),
        .I_PIXEL_COLUMN      (I_PIXEL_COLUMN),
        .I_PIXEL_ROW         (I_PIXEL_ROW),
        .I_PIXEL_MATRIX      (I_PIXEL_MATRIX),
        .I_PIXEL_MATRIX_READY(I_PIXEL_MATRIX_READY),
        .I_THRESHOLD         (I_THRESHOLD),
        .O_PIXEL_COLUMN      (O_PIXEL_COLUMN),
        .O_PIXEL_ROW         (O_PIXEL_ROW),
        .O_EDGE_MAGNITUDE    (O_EDGE_MAGNITUDE),
        .O_EDGE              (O_EDGE),
        .O_VALID             (O_VALID),
        .O_EDGE_COUNT        (O_EDGE_COUNT),
        .O_FRAME_DONE        (O_FRAME_DONE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int col;
        int row;
        int mag;
        int edge_bit;
        int done;
        int count;
        int due;
    } exp_t;

    exp_t q[$];

    // Reference state: dedupe memory and per-frame edge tally
    bit m_seen = 1'b0;
    int m_last_col = 0;
    int m_last_row = 0;
    int m_running = 0;

    // Sobel result straight from the kernel definition
    function automatic exp_t model(input logic [63:0] mat, input int thr, input int col, input int row);
        exp_t e;
        int p[8];
        int gx, gy, mag;
        for (int k = 0; k < 8; k++) p[k] = int'(mat[63-8*k -: 8]);
        // p: 0 tl, 1 t, 2 tr, 3 ml, 4 mr, 5 bl, 6 b, 7 br
        gx  = (p[2] + 2*p[4] + p[7]) - (p[0] + 2*p[3] + p[5]);
        gy  = (p[5] + 2*p[6] + p[7]) - (p[0] + 2*p[1] + p[2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
        e.col = col;
        e.row = row;
        e.mag = mag;
        e.edge_bit = (mag >= thr) ? 1 : 0;
        e.done = 0;
        e.count = 0;
        e.due = 0;
        return e;
    endfunction

    // One driven cycle; predicts and queues a result when the matrix is accepted
    task automatic step(input bit rdy, input int col, input int row, input logic [63:0] mat, input int thr);
        exp_t e;
        @(posedge clk);
        #1;
        I_PIXEL_MATRIX_READY = rdy;
        I_PIXEL_COLUMN       = CB'(col);
        I_PIXEL_ROW          = RB'(row);
        I_PIXEL_MATRIX       = mat;
        I_THRESHOLD          = 8'(thr);
        if (rdy && (!m_seen || col != m_last_col || row != m_last_row)) begin
            m_seen     = 1'b1;
            m_last_col = col;
            m_last_row = row;
            e = model(mat, thr, col, row);
            if (e.edge_bit != 0 && m_running < CNT_MAX) m_running++;
            if (col == LAST_C && row == LAST_R) begin
                e.done    = 1;
                e.count   = m_running;
                m_running = 0;
            end
            e.due = cyc + 3;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 64'h0, 0);
    endtask

    // Synchronous reset for n cycles; anything not yet presented is discarded
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        I_RESET = 1'b1;
        I_PIXEL_MATRIX_READY = 1'b0;
        while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        m_seen    = 1'b0;
        m_running = 0;
        for (int i = 1; i < n; i++) @(posedge clk);
        @(posedge clk);
        #1;
        I_RESET = 1'b0;
    endtask

    // Monitor: pop and compare on every result, check held values otherwise
    int h_col = 0, h_row = 0, h_mag = 0, h_edge = 0, h_count = 0;
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            check("missed_result", 32'(e.due), 32'(cyc));
        end
        if (O_VALID) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 32'(O_VALID), 32'd0);
            end else begin
                e = q.pop_front();
                check("latency",    32'(cyc),              32'(e.due));
                check("column",     32'(O_PIXEL_COLUMN),   32'(e.col));
                check("row",        32'(O_PIXEL_ROW),      32'(e.row));
                check("magnitude",  32'(O_EDGE_MAGNITUDE), 32'(e.mag));
                check("edge",       32'(O_EDGE),           32'(e.edge_bit));
                check("frame_done", 32'(O_FRAME_DONE),     32'(e.done));
                if (e.done != 0) begin
                    check("edge_count", 32'(O_EDGE_COUNT), 32'(e.count));
                    h_count = e.count;
                end
                h_col = e.col; h_row = e.row; h_mag = e.mag; h_edge = e.edge_bit;
            end
        end else if (I_RESET) begin
            h_col = 0; h_row = 0; h_mag = 0; h_edge = 0; h_count = 0;
        end else begin
            check("done_without_valid", 32'(O_FRAME_DONE),     32'd0);
            check("hold_column",        32'(O_PIXEL_COLUMN),   32'(h_col));
            check("hold_row",           32'(O_PIXEL_ROW),      32'(h_row));
            check("hold_magnitude",     32'(O_EDGE_MAGNITUDE), 32'(h_mag));
            check("hold_edge",          32'(O_EDGE),           32'(h_edge));
            check("hold_count",         32'(O_EDGE_COUNT),     32'(h_count));
        end
    end

    // Matrices ordered {tl,t,tr,ml,mr,bl,b,br}
    localparam logic [63:0] M_STEP = {8'd0, 8'd128, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128, 8'd255};
    localparam logic [63:0] M_FLAT = {8{8'd100}};
    localparam logic [63:0] M_WEAK = {8'd0, 8'd0, 8'd10, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10};

    initial begin
        int col, row, thr;
        logic [63:0] mat;

        // Power-on reset, then idle cycles with every output at zero
        repeat (3) @(posedge clk);
        #1;
        I_RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_valid",  32'(O_VALID),          32'd0);
            check("reset_mag",    32'(O_EDGE_MAGNITUDE), 32'd0);
            check("reset_edge",   32'(O_EDGE),           32'd0);
            check("reset_col",    32'(O_PIXEL_COLUMN),   32'd0);
            check("reset_row",    32'(O_PIXEL_ROW),      32'd0);
            check("reset_count",  32'(O_EDGE_COUNT),     32'd0);
            check("reset_done",   32'(O_FRAME_DONE),     32'd0);
        end

        // Saturating step edge held five cycles at one position
        for (int i = 0; i < 5; i++) step(1'b1, 5, 7, M_STEP, 100);
        idle(4);

        // Flat field, then magnitude exactly at and just below the threshold
        step(1'b1, 6, 7, M_FLAT, 50);
        step(1'b1, 7, 7, M_WEAK, 40);
        step(1'b1, 8, 7, M_WEAK, 41);
        idle(4);

        // Back-to-back distinct positions
        step(1'b1, 1, 0, {$urandom, $urandom}, 60);
        step(1'b1, 2, 0, {$urandom, $urandom}, 60);
        step(1'b1, 3, 0, {$urandom, $urandom}, 60);
        idle(4);

        // Short frame: four edges, the last position among them, then a second frame
        do_reset(2);
        step(1'b1, 0, 0, M_STEP, 100);
        step(1'b1, 1, 0, M_FLAT, 100);
        step(1'b1, 2, 0, M_STEP, 100);
        step(1'b1, 2, 0, M_STEP, 100);
        step(1'b1, 0, 1, M_FLAT, 100);
        step(1'b1, 1, 1, M_STEP, 100);
        step(1'b1, 2, 1, M_STEP, 100);
        step(1'b1, 0, 0, M_STEP, 100);
        step(1'b1, 1, 0, M_WEAK, 30);
        step(1'b0, 1, 0, M_WEAK, 30);
        step(1'b1, 1, 0, M_WEAK, 30);
        step(1'b1, 2, 1, M_FLAT, 0);
        idle(5);

        // Reset one cycle after an accept discards it; same position is new afterwards
        step(1'b1, 9, 9, M_STEP, 100);
        do_reset(2);
        step(1'b1, 9, 9, M_STEP, 100);
        idle(5);

        // Randomized traffic with held positions, ready gaps and frame ends
        col = 0;
        row = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(1, 0) == 0) begin
                col = int'($urandom_range(3, 0));
                row = int'($urandom_range(2, 0));
            end
            mat = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) mat = mat & {8{8'h0f}};
            thr = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(255, 0));
            step($urandom_range(3, 0) != 0, col, row, mat, thr);
        end

        // Drain with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        idle(2);
        check("drain_pending", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
